// File: rtl/feature_ram_pkg.sv
// Shared constants and types for blocks that read the feature RAM.
// A point occupies LENGTH consecutive words, so an address is simply {point, feature}.
package feature_ram_pkg;

    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 1024;
    localparam int PT_BITS    = 10;
    localparam int LENGTH     = 16;
    localparam int LEN_BITS   = 4;

    typedef struct packed {
        logic [PT_BITS-1:0]  point;
        logic [LEN_BITS-1:0] feat;
        logic                last_feat;
        logic                last;
    } stream_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } fsm_state_t;

    function automatic logic [ADDR_WIDTH-1:0] pack_addr(input logic [PT_BITS-1:0]  point,
                                                        input logic [LEN_BITS-1:0] feat);
        return {point, feat};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are dropped.
// Storage is not reset, so readers must qualify dout with !empty.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/feature_vector_reader.sv
// Streams the feature words of a contiguous, wrapping range of points out of the feature RAM.
// Reads are only issued against free FIFO credit, so a stalled sink never loses a word.
module feature_vector_reader
    import feature_ram_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PT_BITS-1:0]    pt_first,
    input  logic [PT_BITS:0]      pt_count,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [PT_BITS-1:0]    m_point,
    output logic [LEN_BITS-1:0]   m_feat,
    output logic                  m_last_feat,
    output logic                  m_last
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W = $bits(stream_tag_t) + DATA_WIDTH;

    fsm_state_t          state, state_nx;
    logic [PT_BITS-1:0]  pt_base;
    logic [PT_BITS:0]    pt_total;
    logic [PT_BITS:0]    pt_idx;
    logic [LEN_BITS-1:0] feat_idx;
    logic                done_r;
    logic                accept;
    logic                issue;
    logic                can_issue;
    logic                hs;
    stream_tag_t         issue_tag;
    stream_tag_t         head_tag;
    logic [RD_LAT-1:0]   vld_pipe;
    stream_tag_t         tag_pipe [RD_LAT];
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_W-1:0]   fifo_dout;
    int                  outstanding;

    // done_r extends busy by one cycle so a start coinciding with done is ignored
    assign busy   = (state != ST_IDLE) || done_r;
    assign done   = done_r;
    assign accept = start && !busy;

    always_comb begin
        issue_tag           = '0;
        issue_tag.point     = pt_base + pt_idx[PT_BITS-1:0];
        issue_tag.feat      = feat_idx;
        issue_tag.last_feat = (feat_idx == LEN_BITS'(LENGTH - 1));
        issue_tag.last      = issue_tag.last_feat && (pt_idx == pt_total - 1'b1);
    end

    // Credit counts words already buffered plus reads still travelling through the RAM
    always_comb begin
        outstanding = 32'(fifo_count);
        for (int i = 0; i < RD_LAT; i++) outstanding += 32'(vld_pipe[i]);
    end

    assign can_issue = (outstanding < FIFO_DEPTH) && !fifo_full;
    assign issue     = (state == ST_ISSUE) && can_issue;

    assign ram_cs   = issue;
    assign ram_oe   = issue;
    assign ram_we   = 1'b0;
    assign ram_addr = issue ? pack_addr(issue_tag.point, issue_tag.feat) : '0;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept && pt_count != '0) state_nx = ST_ISSUE;
            ST_ISSUE: if (issue && issue_tag.last) state_nx = ST_DRAIN;
            ST_DRAIN: if (hs && head_tag.last) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            done_r   <= 1'b0;
            pt_base  <= '0;
            pt_total <= '0;
            pt_idx   <= '0;
            feat_idx <= '0;
        end else begin
            state  <= state_nx;
            done_r <= (accept && pt_count == '0) ||
                      (state == ST_DRAIN && hs && head_tag.last);
            if (accept) begin
                pt_base  <= pt_first;
                pt_total <= pt_count;
                pt_idx   <= '0;
                feat_idx <= '0;
            end else if (issue) begin
                feat_idx <= feat_idx + 1'b1;
                if (issue_tag.last_feat) pt_idx <= pt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_pipe[0] <= issue_tag;
        for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_pipe[RD_LAT-1]),
        .pop   (hs),
        .din   ({tag_pipe[RD_LAT-1], ram_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_tag    = stream_tag_t'(fifo_dout[FIFO_W-1:DATA_WIDTH]);
    assign m_valid     = !fifo_empty;
    assign hs          = m_valid && m_ready;
    assign m_data      = m_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
    assign m_point     = m_valid ? head_tag.point : '0;
    assign m_feat      = m_valid ? head_tag.feat : '0;
    assign m_last_feat = m_valid && head_tag.last_feat;
    assign m_last      = m_valid && head_tag.last;

endmodule

// File: tb/tb_feature_vector_reader.sv
// Bench for feature_vector_reader: RAM model holding a*3+7, an expected word/address queue
// built from the point range, and a negedge monitor that scores every read and handshake.
module tb_feature_vector_reader;
    import feature_ram_pkg::*;

    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int BUDGET     = 3000;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [PT_BITS-1:0]    pt_first = '0;
    logic [PT_BITS:0]      pt_count = '0;
    logic                  busy, done, ram_cs, ram_we, ram_oe;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  m_valid;
    logic                  m_ready = 1'b1;
    logic [DATA_WIDTH-1:0] m_data;
    logic [PT_BITS-1:0]    m_point;
    logic [LEN_BITS-1:0]   m_feat;
    logic                  m_last_feat, m_last;

    feature_vector_reader #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .pt_first(pt_first), .pt_count(pt_count),
        .busy(busy), .done(done), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_data(ram_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_point(m_point), .m_feat(m_feat), .m_last_feat(m_last_feat),
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          point;
        int          feat;
        bit          lf;
        bit          last;
    } exp_t;

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
    exp_t exp_q [$];
    int   addr_q [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   n_cs, n_hs, n_done, first_cs, first_vld, first_hs, last_hs, done_cyc;
    bit   stall_prev;
    logic [DATA_WIDTH-1:0] h_data;
    logic [PT_BITS-1:0]    h_point;
    logic [LEN_BITS-1:0]   h_feat;
    logic                  h_lf, h_last;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_cs) ram_data <= mem[ram_addr];
    end

    initial begin
        for (int a = 0; a < (1 << ADDR_WIDTH); a++) mem[a] = 32'(a * 3 + 7);
    end

    // Scoreboard: reads in address order, handshakes in stream order, hold-while-stalled
    initial forever begin
        @(negedge clk);
        if (!mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (ram_cs) begin
                n_cs++;
                if (first_cs < 0) first_cs = cyc;
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL ram_read: unexpected read addr=%0d", ram_addr);
                end else begin
                    int a;
                    a = addr_q.pop_front();
                    if (ram_addr !== ADDR_WIDTH'(a) || ram_we !== 1'b0 || ram_oe !== 1'b1) begin
                        errors++;
                        $display("FAIL ram_read: addr=%0d we=%b oe=%b, want addr=%0d we=0 oe=1",
                                 ram_addr, ram_we, ram_oe, a);
                    end
                end
                checks++;
                if (n_cs - n_hs > FIFO_DEPTH) begin
                    errors++;
                    $display("FAIL occupancy: %0d words outstanding, limit %0d", n_cs - n_hs, FIFO_DEPTH);
                end
            end
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (stall_prev) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== h_data || m_point !== h_point ||
                    m_feat !== h_feat || m_last_feat !== h_lf || m_last !== h_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%0d point=%0d feat=%0d, want 1 %0d %0d %0d",
                             m_valid, m_data, m_point, m_feat, h_data, h_point, h_feat);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word: extra word data=%0d point=%0d", m_data, m_point);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (m_data !== e.data || m_point !== PT_BITS'(e.point) || m_feat !== LEN_BITS'(e.feat) ||
                        m_last_feat !== e.lf || m_last !== e.last) begin
                        errors++;
                        $display("FAIL word[%0d]: data=%0d point=%0d feat=%0d lf=%b last=%b, want %0d %0d %0d %b %b",
                                 n_hs, m_data, m_point, m_feat, m_last_feat, m_last,
                                 e.data, e.point, e.feat, e.lf, e.last);
                    end
                end
                n_hs++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            stall_prev = m_valid && !m_ready;
            h_data = m_data; h_point = m_point; h_feat = m_feat; h_lf = m_last_feat; h_last = m_last;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        exp_q.delete(); addr_q.delete();
        n_cs = 0; n_hs = 0; n_done = 0; first_cs = -1; first_vld = -1;
        first_hs = -1; last_hs = -1; done_cyc = -1; stall_prev = 1'b0;
    endtask

    task automatic build_expect(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            int p;
            p = (first + i) % DEPTH;
            for (int f = 0; f < LENGTH; f++) begin
                int a;
                a = p * LENGTH + f;
                addr_q.push_back(a);
                exp_q.push_back('{32'(a * 3 + 7), p, f, f == LENGTH - 1, (i == count - 1) && (f == LENGTH - 1)});
            end
        end
    endtask

    // Drives one command and sinks the stream until done (mode 0 ready, 1 one-in-three, 2 random)
    task automatic run_cmd(input int first, input int count, input int mode, output int st_cyc);
        int c;
        clear_stats();
        build_expect(first, count);
        mon_en = 1'b1;
        pt_first = PT_BITS'(first);
        pt_count = (PT_BITS+1)'(count);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        st_cyc = cyc;
        c = 0;
        while (n_done == 0 && c < BUDGET) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (c % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            c++;
        end
        m_ready = 1'b1;
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL timeout: no done within %0d cycles (first=%0d count=%0d)", BUDGET, first, count);
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({busy, done, ram_cs, ram_we, ram_oe, ram_addr, m_valid, m_data, m_point, m_feat,
             m_last_feat, m_last} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b cs=%b addr=%0d valid=%b data=%0d, want all 0",
                     busy, done, ram_cs, ram_addr, m_valid, m_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_point();
        int st;
        run_cmd(2, 1, 0, st);
        checks++;
        if (n_hs != 16 || exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL single_count: words=%0d left=%0d, want 16 0", n_hs, exp_q.size());
        end
        checks++;
        if (last_hs - first_hs + 1 != n_hs) begin
            errors++;
            $display("FAIL single_streaming: span=%0d cycles for %0d words", last_hs - first_hs + 1, n_hs);
        end
        checks++;
        if (first_vld - first_cs != RD_LAT + 1) begin
            errors++;
            $display("FAIL single_latency: %0d cycles issue->valid, want %0d", first_vld - first_cs, RD_LAT + 1);
        end
        checks++;
        if (n_done != 1 || done_cyc != last_hs + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: pulses=%0d at %0d busy=%b, want 1 at %0d busy=0",
                     n_done, done_cyc, busy, last_hs + 1);
        end
    endtask

    task automatic test_wrap();
        int st;
        run_cmd(1023, 2, 0, st);
        checks++;
        if (n_hs != 32 || n_cs != 32 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_count: words=%0d reads=%0d, want 32 32", n_hs, n_cs);
        end
        checks++;
        if (n_done != 1 || done_cyc != last_hs + 1 || last_hs - first_hs + 1 != 32) begin
            errors++;
            $display("FAIL wrap_done: pulses=%0d at %0d span=%0d, want 1 at %0d span 32",
                     n_done, done_cyc, last_hs - first_hs + 1, last_hs + 1);
        end
    endtask

    task automatic test_backpressure();
        int st;
        run_cmd(int'($urandom_range(0, DEPTH - 1)), 3, 1, st);
        checks++;
        if (n_hs != 48 || exp_q.size() != 0 || n_done != 1 || done_cyc != last_hs + 1) begin
            errors++;
            $display("FAIL backpressure: words=%0d left=%0d done=%0d at %0d, want 48 0 1 at %0d",
                     n_hs, exp_q.size(), n_done, done_cyc, last_hs + 1);
        end
        for (int k = 0; k < 2; k++) begin
            int cnt;
            cnt = int'($urandom_range(1, 4));
            run_cmd(int'($urandom_range(0, DEPTH - 1)), cnt, 2, st);
            checks++;
            if (n_hs != cnt * LENGTH || exp_q.size() != 0 || n_done != 1) begin
                errors++;
                $display("FAIL random_ready: words=%0d left=%0d done=%0d, want %0d 0 1",
                         n_hs, exp_q.size(), n_done, cnt * LENGTH);
            end
        end
    endtask

    task automatic test_zero_count();
        int st;
        run_cmd(7, 0, 0, st);
        checks++;
        if (n_done != 1 || done_cyc != st || n_cs != 0 || first_vld != -1) begin
            errors++;
            $display("FAIL zero_count: done=%0d at %0d reads=%0d valid_at=%0d, want 1 at %0d 0 -1",
                     n_done, done_cyc, n_cs, first_vld, st);
        end
    endtask

    task automatic test_reset_mid();
        int c, st;
        clear_stats();
        build_expect(40, 2);
        mon_en = 1'b1;
        pt_first = PT_BITS'(40); pt_count = (PT_BITS+1)'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (n_hs < 10 && c < BUDGET) begin @(posedge clk); #1; c++; end
        checks++;
        if (n_hs < 10) begin
            errors++;
            $display("FAIL reset_mid_wait: only %0d words before timeout", n_hs);
        end
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, ram_cs, ram_we, ram_oe, ram_addr, m_valid, m_data, m_point, m_feat,
             m_last_feat, m_last} !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: busy=%b done=%b cs=%b valid=%b data=%0d, want all 0",
                     busy, done, ram_cs, m_valid, m_data);
        end
        clear_stats();
        mon_en = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        checks++;
        if (n_done != 0 || n_hs != 0 || n_cs != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: done=%0d words=%0d reads=%0d, want 0 0 0", n_done, n_hs, n_cs);
        end
        run_cmd(5, 1, 0, st);
        checks++;
        if (n_hs != 16 || exp_q.size() != 0 || n_done != 1) begin
            errors++;
            $display("FAIL reset_mid_restart: words=%0d left=%0d done=%0d, want 16 0 1", n_hs, exp_q.size(), n_done);
        end
    endtask

    task automatic test_start_while_busy();
        int c;
        clear_stats();
        build_expect(300, 2);
        mon_en = 1'b1;
        pt_first = PT_BITS'(300); pt_count = (PT_BITS+1)'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        pt_first = PT_BITS'(100); pt_count = (PT_BITS+1)'(3); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (exp_q.size() != 0 && c < BUDGET) begin @(posedge clk); #1; c++; end
        // this is the done cycle: a start here must also be ignored
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_done_cycle: done=%b busy=%b, want 1 1", done, busy);
        end
        pt_first = PT_BITS'(9); pt_count = (PT_BITS+1)'(1); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        checks++;
        if (n_hs != 32 || n_cs != 32 || n_done != 1 || m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: words=%0d reads=%0d done=%0d valid=%b busy=%b, want 32 32 1 0 0",
                     n_hs, n_cs, n_done, m_valid, busy);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_point();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_reset_mid();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/feature_vector_reader.md
Name: feature_vector_reader

Overview:
- Downstream consumer of the feature RAM, which holds DEPTH data points × LENGTH 32-bit features. Point p, feature f is at addr = {p, f}, i.e. p*LENGTH + f.
- On a start command, the block sequences RAM reads for a contiguous range of points and streams each feature word out on a valid/ready interface.
- The stream output feeds the distance/compute stage.
- Read latency is absorbed by a small credit-controlled FIFO, so the stream sustains one word per cycle when the sink is always ready.

Parameters:
- ADDR_WIDTH, 14, RAM address width; must equal PT_BITS+LEN_BITS.
- DATA_WIDTH, 32, RAM word / feature width.
- DEPTH, 1024, number of data points in RAM.
- PT_BITS, 10, log2(DEPTH).
- LENGTH, 16, features per point.
- LEN_BITS, 4, log2(LENGTH).
- RD_LAT, 1, cycles from RAM address/strobe to valid ram_data.
- FIFO_DEPTH, 4, output buffer entries; must be ≥ RD_LAT+1 and a power of two.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle command pulse; ignored while busy.
- pt_first  in  PT_BITS  first point index, sampled on an accepted start.
- pt_count  in  PT_BITS+1  number of points, range 0..DEPTH, sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable; tied 0, this block never writes.
- ram_oe  out  1  RAM output enable; 1 whenever ram_cs=1.
- ram_addr  out  ADDR_WIDTH  RAM address {point, feature}.
- ram_data  in  DATA_WIDTH  RAM read data. The block never drives the bus; the top level resolves the tristate.
- m_valid  out  1  stream word valid.
- m_ready  in  1  sink ready.
- m_data  out  DATA_WIDTH  feature value.
- m_point  out  PT_BITS  point index of the word.
- m_feat  out  LEN_BITS  feature index of the word.
- m_last_feat  out  1  word is feature LENGTH-1 of its point.
- m_last  out  1  final word of the command.

Behaviour:
- Reset values: busy=0, done=0, ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0, m_valid=0, m_data=0, m_point=0, m_feat=0, m_last_feat=0, m_last=0.
- Reset mid-operation: FIFO flushed, in-flight reads discarded, FSM returns to IDLE. No done pulse is generated.
- FSM states:
  - IDLE: on start with pt_count≠0, latch the range, clear the issue counters, go to ISSUE.
  - IDLE: on start with pt_count=0, pulse done on the next cycle and stay in IDLE; no RAM access.
  - ISSUE: issue one read per cycle while credit is available. After the last address (point count-1, feature LENGTH-1) is issued, go to DRAIN.
  - DRAIN: wait for the last word to be accepted (m_valid & m_ready & m_last), then assert done for 1 cycle and go to IDLE.
- Issue rule: ram_cs=ram_oe=1 only in a cycle where a read is issued. Credit = FIFO_DEPTH − (fifo occupancy + reads in flight). A read is issued only if credit > 0, so the FIFO never overflows and no word is lost when m_ready is held low.
- Return path: ram_data is captured RD_LAT cycles after issue, together with its tag {point, feature, last_feat, last}, which is delayed in a RD_LAT-deep shift register.
- Latency: first m_valid appears RD_LAT+1 cycles after the first issue. With m_ready=1 throughout, total words = pt_count*LENGTH, delivered in consecutive cycles.
- Point wrap: point index = (pt_first + i) mod DEPTH. Example: pt_first=1023, pt_count=2 reads points 1023 then 0.
- Feature counter wraps LENGTH-1→0 and increments the point counter. Counter widths are exact with no saturation; the issue counter is PT_BITS+1 bits so pt_count=DEPTH is representable.
- Stream rules:
  - m_data, m_point, m_feat, m_last_feat and m_last are held stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - m_ready may toggle arbitrarily.
- Simultaneous events:
  - FIFO push and pop in the same cycle keep occupancy unchanged.
  - A start in the same cycle as done is ignored, because busy is still high in that cycle.
  - A start in any busy cycle is ignored.

Decomposition:
- Shared package feature_ram_pkg holds:
  - the ADDR_WIDTH, DATA_WIDTH, DEPTH, PT_BITS, LENGTH and LEN_BITS constants;
  - the address-packing function {point, feature};
  - the stream tag struct {point, feat, last_feat, last};
  - the FSM state enum.
- One sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/count, synchronous active-high reset. It stores {tag, data}.

Test Plan:
- Preload RAM addr a with a*3+7. Send start, pt_first=2, pt_count=1, m_ready=1. Expect 16 words 103..148 in consecutive cycles, m_point=2, m_feat 0..15, m_last_feat and m_last on word 15, done 1 cycle after the last handshake.
- Send pt_first=1023, pt_count=2. Expect addresses 16368..16383 then 0..15; m_point 1023 then 0; m_last only on the final word (data 52).
- Send pt_count=3 with m_ready toggling (1 cycle high, 2 low). Expect 48 words, none lost or duplicated, in order. The bench's FIFO-occupancy check must never see it exceed 4, and data must be held stable while stalled.
- Send pt_count=0. Expect done 1 cycle later, ram_cs never asserted, m_valid stays 0.
- Assert rst for 1 cycle after the 10th word of a pt_count=2 run. Expect all outputs at reset values the next cycle and no done pulse. A following start with pt_first=5, pt_count=1 returns 247..292 correctly.
- Send a second start while busy. Expect it ignored: the word count matches only the first command and exactly one done pulse.
